palette_multi: RTL and testbench
================================

Name: palette_multi

Overview:
- Parametrised successor to the 6-bit palette RAM.
- Configurable entry count and channel depth, covering 2-bit/channel (SMS) and 4-bit/channel (GG-style 12-bit) colours.
- Multi-byte CPU write protocol with a low-byte latch, registered CPU readback, and a registered video lookup with blanking.
- Power-up clear sequencer. Sits between the CPU I/O decode and the video pixel pipeline.

Parameters:
- IDX_W, 5, palette index width; ENTRIES = 2**IDX_W.
- CH_W, 2, bits per colour channel, legal 1..5.
- Derived: EW = 3*CH_W (entry width); TWO_BYTE = (EW > 8); AW = IDX_W + TWO_BYTE.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- wr_addr  in  AW  CPU byte address; when TWO_BYTE, bit 0 is the byte select and bits [AW-1:1] are the entry
- wr_data  in  8  CPU write byte
- wr_en  in  1  CPU write strobe, one cycle per byte
- rd_addr  in  AW  CPU readback address, same layout as wr_addr
- rd_data  out  8  registered readback byte
- palidx  in  IDX_W  video lookup index
- blank  in  1  force black output
- pal_r, pal_g, pal_b  out  CH_W each  registered colour
- busy  out  1  clear sequencer active

Behaviour:
- Entry packing is {B,G,R} with R in the LSBs.
  - Byte 0 = entry[7:0].
  - Byte 1 = entry[EW-1:8], zero-extended; exists only when TWO_BYTE.
  - Single-byte mode: entry = wr_data[EW-1:0]; upper bits are ignored.
- Reset (async assert, sync release): rd_data=0, pal_*=0, latch=0, clear counter=0, state=CLEAR, busy=1. RAM contents are not reset directly.
- FSM states:
  - CLEAR: write 0 to entry clr_cnt each cycle and increment clr_cnt. After the ENTRIES-1 write, go to RUN next cycle. busy=1 for exactly ENTRIES cycles after reset release.
  - RUN: normal operation, busy=0. There is no return to CLEAR except via reset.
- CPU writes while busy=1 are dropped, including latch updates. Video outputs are held at 0 while busy.
- Write protocol when TWO_BYTE:
  - wr_en with byte-select 0: latch <= wr_data. RAM is unchanged.
  - wr_en with byte-select 1: RAM[entry] <= {wr_data[EW-9:0], latch}. Latch is retained, so repeated commits reuse the same low byte.
  - A commit without a preceding low-byte write uses the current latch value (0 after reset).
- Write protocol when single-byte: every wr_en commits immediately.
- Readback: rd_data <= selected byte of RAM[rd_addr] every cycle, latency 1.
  - Returns the stored RAM value, never the latch.
  - Readback is valid during busy.
- Video path: pal_* <= blank|busy ? 0 : RAM[palidx] fields, latency 1.
- Same-cycle write and read of the same entry: both the video and readback ports register the OLD value; the new value is visible the following cycle.
- Reset asserted mid-CLEAR restarts CLEAR from entry 0.

Decomposition:
- palette_pkg holds:
  - entry-width and byte-count localparam functions;
  - pack/unpack functions (entry <-> {r,g,b}, entry <-> byte n);
  - the FSM state enum {CLEAR, RUN}.
- Sub-module palette_ram: ENTRIES x EW storage.
  - One synchronous write port.
  - Two asynchronous read ports, mapping to distributed RAM.
  - No reset.

Test Plan:
- Reset release with CH_W=4, IDX_W=5 -> busy high for exactly 32 cycles; readback of every byte then returns 0x00; pal_* = 0 for all palidx.
- CH_W=4, RUN: write 0x5A to byte 0 of entry 3 -> readback of entry 3 byte 0 still 0x00. Then write 0x0C to byte 1 -> readback bytes 0x5A / 0x0C. Then palidx=3 gives r=0xA, g=0x5, b=0xC one cycle later.
- CH_W=4: commit 0x01 to byte 1 of entry 7 without a new byte-0 write -> entry 7 = {1, latch}; with the latch holding 0x5A, r=0xA, g=0x5, b=0x1.
- CH_W=2 (single-byte): write 0xFF to address 9 -> readback 0x3F; palidx=9 gives r=3, g=3, b=3. Asserting blank -> all outputs 0 next cycle.
- Same-cycle write of 0x2A to entry 4 and palidx=4 (CH_W=2, entry previously 0x15) -> cycle 1 outputs r=1, g=1, b=1 (old value); cycle 2 outputs r=2, g=2, b=2.
- Writes issued during busy, and reset_n pulsed low at clear cycle 10 -> writes are dropped; busy restarts and lasts 32 full cycles; all entries read 0 afterwards.

Source files
------------

// File: rtl/palette_pkg.sv
// palette_pkg
// Shared types and helpers for the parametrised palette RAM.
//   - entry_w / byte_cnt : entry width and CPU byte count for a channel depth
//   - pack_bytes         : CPU {hi, lo} byte pair -> 16-bit entry image
//   - entry_byte         : select CPU byte n of a zero-extended entry
//   - unpack_ch/pack_rgb : entry <-> {r, g, b} channel fields (R in the LSBs)
//   - state_e            : clear sequencer states
package palette_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    function automatic int entry_w(input int ch_w);
        return 3 * ch_w;
    endfunction

    function automatic int byte_cnt(input int ch_w);
        return (3 * ch_w > 8) ? 2 : 1;
    endfunction

    function automatic logic [15:0] pack_bytes(input logic [7:0] lo, input logic [7:0] hi);
        return {hi, lo};
    endfunction

    // Callers zero-extend the entry first, so byte 1 of a narrow entry is 0.
    function automatic logic [7:0] entry_byte(input logic [15:0] e, input logic sel);
        return sel ? e[15:8] : e[7:0];
    endfunction

    // Channel n (0=R, 1=G, 2=B) of an entry packed as {B,G,R}.
    function automatic logic [4:0] unpack_ch(input logic [15:0] e, input int ch_w, input int n);
        logic [15:0] s;
        logic [15:0] mask;
        s    = e >> (n * ch_w);
        mask = 16'((32'd1 << ch_w) - 32'd1);
        return 5'(s & mask);
    endfunction

    function automatic logic [15:0] pack_rgb(input logic [4:0] r, input logic [4:0] g,
                                             input logic [4:0] b, input int ch_w);
        return 16'(r) | (16'(g) << ch_w) | (16'(b) << (2 * ch_w));
    endfunction

endpackage

// File: rtl/palette_ram.sv
// palette_ram
// 2**IDX_W x EW storage, one synchronous write port and two asynchronous
// read ports (maps onto distributed RAM). Contents are not reset; the
// owning block clears them with a sequencer.
//   clk              : write clock
//   we/waddr/wdata   : write port
//   raddr_a/rdata_a  : read port A (video lookup)
//   raddr_b/rdata_b  : read port B (CPU readback)
module palette_ram
    import palette_pkg::*;
#(
    parameter int IDX_W = 5,
    parameter int EW    = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [EW-1:0]    wdata,
    input  logic [IDX_W-1:0] raddr_a,
    output logic [EW-1:0]    rdata_a,
    input  logic [IDX_W-1:0] raddr_b,
    output logic [EW-1:0]    rdata_b
);

    logic [EW-1:0] mem [2**IDX_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads are combinational, so a same-cycle write is seen only after the edge.
    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/palette_multi.sv
// palette_multi
// Parametrised palette RAM between CPU I/O decode and the video pipeline.
// Entries are {B,G,R}, CH_W bits per channel. When an entry is wider than a
// byte the CPU writes the low byte into a latch (byte-select 0) and commits
// the whole entry with the high byte (byte-select 1).
// After reset a sequencer zeroes every entry; busy is high meanwhile, CPU
// writes are dropped and the video outputs are held at 0.
//   clk, reset_n        : clock, async active-low reset
//   wr_addr/wr_data/wr_en : CPU byte write ({entry, byte_sel} when two-byte)
//   rd_addr/rd_data     : CPU readback, one cycle latency
//   palidx/blank        : video lookup index, force-black
//   pal_r/pal_g/pal_b   : registered colour, one cycle latency
//   busy                : clear sequencer active
module palette_multi
    import palette_pkg::*;
#(
    parameter  int IDX_W    = 5,
    parameter  int CH_W     = 2,
    localparam int EW       = entry_w(CH_W),
    localparam bit TWO_BYTE = (byte_cnt(CH_W) == 2),
    localparam int AW       = IDX_W + (TWO_BYTE ? 1 : 0)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [AW-1:0]    wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [7:0]       rd_data,
    input  logic [IDX_W-1:0] palidx,
    input  logic             blank,
    output logic [CH_W-1:0]  pal_r,
    output logic [CH_W-1:0]  pal_g,
    output logic [CH_W-1:0]  pal_b,
    output logic             busy
);

    localparam int ENTRIES = 2**IDX_W;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic [CH_W-1:0]  pal_r_q, pal_r_d;
    logic [CH_W-1:0]  pal_g_q, pal_g_d;
    logic [CH_W-1:0]  pal_b_q, pal_b_d;
    logic             busy_w;

    // CPU address decode and write data, shaped by the byte protocol
    logic [IDX_W-1:0] wr_ent;
    logic [IDX_W-1:0] rd_ent;
    logic             rd_sel;
    logic             cpu_commit;
    logic [EW-1:0]    cpu_wdata;

    // RAM port signals
    logic             ram_we;
    logic [IDX_W-1:0] ram_waddr;
    logic [EW-1:0]    ram_wdata;
    logic [EW-1:0]    ram_rd_vid;
    logic [EW-1:0]    ram_rd_cpu;

    generate
        if (TWO_BYTE) begin : g_two_byte
            logic [7:0] latch_q, latch_d;

            assign wr_ent     = wr_addr[AW-1:1];
            assign rd_ent     = rd_addr[AW-1:1];
            assign rd_sel     = rd_addr[0];
            assign cpu_commit = wr_en & wr_addr[0];
            // Truncation keeps wr_data[EW-9:0] above the latched low byte.
            assign cpu_wdata  = EW'(pack_bytes(latch_q, wr_data));

            // Latch survives commits so one low byte can feed many entries.
            always_comb begin
                latch_d = latch_q;
                if (wr_en && !wr_addr[0] && !busy_w) begin
                    latch_d = wr_data;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    latch_q <= 8'h00;
                end else begin
                    latch_q <= latch_d;
                end
            end
        end else begin : g_one_byte
            assign wr_ent     = wr_addr;
            assign rd_ent     = rd_addr;
            assign rd_sel     = 1'b0;
            assign cpu_commit = wr_en;
            assign cpu_wdata  = EW'(wr_data);
        end
    endgenerate

    // Clear sequencer and RAM write arbitration
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy_w    = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = wr_ent;
        ram_wdata = cpu_wdata;
        case (state_q)
            CLEAR: begin
                busy_w    = 1'b1;
                ram_we    = 1'b1;
                ram_waddr = clr_cnt_q;
                ram_wdata = '0;
                clr_cnt_d = clr_cnt_q + IDX_W'(1);
                if (clr_cnt_q == IDX_W'(ENTRIES - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                ram_we = cpu_commit;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    palette_ram #(
        .IDX_W (IDX_W),
        .EW    (EW)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .raddr_a (palidx),
        .rdata_a (ram_rd_vid),
        .raddr_b (rd_ent),
        .rdata_b (ram_rd_cpu)
    );

    // Output registers; both read the pre-write RAM value on a collision.
    always_comb begin
        rd_data_d = entry_byte(16'(ram_rd_cpu), rd_sel);
        pal_r_d   = '0;
        pal_g_d   = '0;
        pal_b_d   = '0;
        if (!(blank || busy_w)) begin
            pal_r_d = CH_W'(unpack_ch(16'(ram_rd_vid), CH_W, 0));
            pal_g_d = CH_W'(unpack_ch(16'(ram_rd_vid), CH_W, 1));
            pal_b_d = CH_W'(unpack_ch(16'(ram_rd_vid), CH_W, 2));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            rd_data_q <= 8'h00;
            pal_r_q   <= '0;
            pal_g_q   <= '0;
            pal_b_q   <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rd_data_q <= rd_data_d;
            pal_r_q   <= pal_r_d;
            pal_g_q   <= pal_g_d;
            pal_b_q   <= pal_b_d;
        end
    end

    assign rd_data = rd_data_q;
    assign pal_r   = pal_r_q;
    assign pal_g   = pal_g_q;
    assign pal_b   = pal_b_q;
    assign busy    = busy_w;

endmodule

// File: tb/tb_palette_multi.sv
module tb_palette_multi;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // 12-bit colour instance (two-byte protocol)
    logic [5:0] wa4, ra4;
    logic [7:0] wd4, rd4;
    logic       we4, bl4, busy4;
    logic [4:0] pi4;
    logic [3:0] r4, g4, b4;

    // 6-bit colour instance (single-byte protocol)
    logic [4:0] wa2, ra2, pi2;
    logic [7:0] wd2, rd2;
    logic       we2, bl2, busy2;
    logic [1:0] r2, g2, b2;

    palette_multi #(.IDX_W(5), .CH_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .wr_addr(wa4), .wr_data(wd4), .wr_en(we4),
        .rd_addr(ra4), .rd_data(rd4), .palidx(pi4), .blank(bl4),
        .pal_r(r4), .pal_g(g4), .pal_b(b4), .busy(busy4)
    );

    palette_multi #(.IDX_W(5), .CH_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .wr_addr(wa2), .wr_data(wd2), .wr_en(we2),
        .rd_addr(ra2), .rd_data(rd2), .palidx(pi2), .blank(bl2),
        .pal_r(r2), .pal_g(g2), .pal_b(b2), .busy(busy2)
    );

    // Reference model: entry values as plain integers
    int m4[32];
    int m2[32];
    int latch4;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        bit we; int wa; int wd; int ra; int pi; bit bl;
        int e_rd; int e_r; int e_g; int e_b;
    } vec_t;
    vec_t tbl[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m4[i] = 0;
            m2[i] = 0;
        end
        latch4 = 0;
    endtask

    function automatic int byte4(input int a);
        return (a % 2 == 1) ? m4[a / 2] / 256 : m4[a / 2] % 256;
    endfunction

    task automatic wr4(input int a, input int d);
        we4 = 1'b1; wa4 = 6'(a); wd4 = 8'(d);
        tick();
        we4 = 1'b0;
        if (a % 2 == 1) m4[a / 2] = (d % 16) * 256 + latch4;
        else latch4 = d;
    endtask

    task automatic probe4(input string nm, input int ra, input int pi, input bit bl,
                          input int er, input int eR, input int eG, input int eB);
        ra4 = 6'(ra); pi4 = 5'(pi); bl4 = bl;
        tick();
        chk({nm, "_rd4"}, int'(rd4), er);
        chk({nm, "_r4"}, int'(r4), eR);
        chk({nm, "_g4"}, int'(g4), eG);
        chk({nm, "_b4"}, int'(b4), eB);
    endtask

    task automatic probe2(input string nm, input int ra, input int pi, input bit bl,
                          input int er, input int eR, input int eG, input int eB);
        ra2 = 5'(ra); pi2 = 5'(pi); bl2 = bl;
        tick();
        chk({nm, "_rd2"}, int'(rd2), er);
        chk({nm, "_r2"}, int'(r2), eR);
        chk({nm, "_g2"}, int'(g2), eG);
        chk({nm, "_b2"}, int'(b2), eB);
    endtask

    task automatic sweep_zero(input string nm);
        for (int e = 0; e < 32; e++) begin
            probe4(nm, e * 2, e, 1'b0, 0, 0, 0, 0);
            ra4 = 6'(e * 2 + 1);
            tick();
            chk({nm, "_hi4"}, int'(rd4), 0);
            probe2(nm, e, e, 1'b0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        int c4, c2;
        we4 = 0; wa4 = 0; wd4 = 0; ra4 = 0; pi4 = 0; bl4 = 0;
        we2 = 0; wa2 = 0; wd2 = 0; ra2 = 0; pi2 = 0; bl2 = 0;
        model_reset();

        // Reset state
        tick(); tick();
        chk("rst_rd4", int'(rd4), 0);
        chk("rst_rgb4", int'({r4, g4, b4}), 0);
        chk("rst_busy4", int'(busy4), 1);
        chk("rst_rd2", int'(rd2), 0);
        chk("rst_rgb2", int'({r2, g2, b2}), 0);
        chk("rst_busy2", int'(busy2), 1);

        // Release; busy must last exactly 32 cycles, writes meanwhile dropped
        reset_n = 1'b1;
        c4 = -1; c2 = -1;
        for (int i = 1; i <= 100; i++) begin
            we4 = 0; we2 = 0;
            if (i == 5) begin we4 = 1; wa4 = 6'd0; wd4 = 8'hEE; end
            if (i == 20) begin
                we4 = 1; wa4 = 6'd5; wd4 = 8'h0F;
                we2 = 1; wa2 = 5'd2; wd2 = 8'h3F;
            end
            tick();
            if (c4 < 0 && !busy4) c4 = i;
            if (c2 < 0 && !busy2) c2 = i;
            if (c4 >= 0 && c2 >= 0) break;
        end
        we4 = 0; we2 = 0;
        chk("busy_len4", c4, 32);
        chk("busy_len2", c2, 32);
        sweep_zero("clr");

        // Latch write during busy was dropped: commit uses latch = 0
        wr4(11, 8'h03);
        probe4("latch_drop_lo", 10, 5, 1'b0, 0, 0, 0, 3);
        probe4("latch_drop_hi", 11, 5, 1'b0, 3, 0, 0, 3);

        // Two-byte protocol
        wr4(6, 8'h5A);
        probe4("lo_only", 6, 3, 1'b0, 8'h00, 0, 0, 0);
        wr4(7, 8'h0C);
        probe4("commit_lo", 6, 3, 1'b0, 8'h5A, 4'hA, 4'h5, 4'hC);
        probe4("commit_hi", 7, 3, 1'b0, 8'h0C, 4'hA, 4'h5, 4'hC);
        wr4(15, 8'h01);
        probe4("reuse_latch", 14, 7, 1'b0, 8'h5A, 4'hA, 4'h5, 4'h1);
        probe4("reuse_hi", 15, 7, 1'b1, 8'h01, 0, 0, 0);

        // Single-byte table: write, latency, blank, same-cycle collision
        tbl[0] = '{1'b1, 9, 8'hFF, 9, 9, 1'b0, 0, 0, 0, 0};
        tbl[1] = '{1'b0, 0, 0, 9, 9, 1'b0, 8'h3F, 3, 3, 3};
        tbl[2] = '{1'b0, 0, 0, 9, 9, 1'b1, 8'h3F, 0, 0, 0};
        tbl[3] = '{1'b1, 4, 8'h15, 4, 4, 1'b0, 0, 0, 0, 0};
        tbl[4] = '{1'b1, 4, 8'h2A, 4, 4, 1'b0, 8'h15, 1, 1, 1};
        tbl[5] = '{1'b0, 0, 0, 4, 4, 1'b0, 8'h2A, 2, 2, 2};
        tbl[6] = '{1'b1, 31, 8'hC6, 31, 31, 1'b0, 0, 0, 0, 0};
        tbl[7] = '{1'b0, 0, 0, 31, 31, 1'b0, 8'h06, 2, 1, 0};
        tbl[8] = '{1'b1, 0, 8'h39, 9, 0, 1'b0, 8'h3F, 0, 0, 0};
        tbl[9] = '{1'b0, 0, 0, 0, 0, 1'b0, 8'h39, 1, 2, 3};
        for (int i = 0; i < 10; i++) begin
            we2 = tbl[i].we; wa2 = 5'(tbl[i].wa); wd2 = 8'(tbl[i].wd);
            probe2($sformatf("tbl%0d", i), tbl[i].ra, tbl[i].pi, tbl[i].bl,
                   tbl[i].e_rd, tbl[i].e_r, tbl[i].e_g, tbl[i].e_b);
            if (tbl[i].we) m2[tbl[i].wa] = tbl[i].wd % 64;
        end
        we2 = 0;

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            int e, er4, eR4, eG4, eB4, er2, eR2, eG2, eB2;
            we4 = 1'($urandom % 2); wa4 = 6'($urandom); wd4 = 8'($urandom);
            ra4 = 6'($urandom); pi4 = 5'($urandom); bl4 = ($urandom % 8 == 0);
            we2 = 1'($urandom % 2); wa2 = 5'($urandom); wd2 = 8'($urandom);
            ra2 = 5'($urandom); pi2 = 5'($urandom); bl2 = ($urandom % 8 == 0);
            er4 = byte4(int'(ra4));
            e = bl4 ? 0 : m4[pi4];
            eR4 = e % 16; eG4 = (e / 16) % 16; eB4 = e / 256;
            er2 = m2[ra2];
            e = bl2 ? 0 : m2[pi2];
            eR2 = e % 4; eG2 = (e / 4) % 4; eB2 = e / 16;
            if (we4) begin
                if (wa4 % 2 == 1) m4[wa4 / 2] = (int'(wd4) % 16) * 256 + latch4;
                else latch4 = int'(wd4);
            end
            if (we2) m2[wa2] = int'(wd2) % 64;
            tick();
            chk("rnd_rd4", int'(rd4), er4);
            chk("rnd_rgb4", int'({b4, g4, r4}), eB4 * 256 + eG4 * 16 + eR4);
            chk("rnd_rd2", int'(rd2), er2);
            chk("rnd_rgb2", int'({b2, g2, r2}), eB2 * 16 + eG2 * 4 + eR2);
        end
        we4 = 0; we2 = 0; bl4 = 0; bl2 = 0;

        // Reset pulse at clear cycle 10, writes hammered throughout busy
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            we4 = 1; wa4 = 6'($urandom); wd4 = 8'($urandom);
            we2 = 1; wa2 = 5'($urandom); wd2 = 8'($urandom);
            tick();
        end
        reset_n = 1'b0;
        #2;
        chk("pulse_rd4", int'(rd4), 0);
        chk("pulse_busy4", int'(busy4), 1);
        reset_n = 1'b1;
        model_reset();
        c4 = -1; c2 = -1;
        for (int i = 1; i <= 100; i++) begin
            we4 = 1; wa4 = 6'($urandom); wd4 = 8'($urandom);
            we2 = 1; wa2 = 5'($urandom); wd2 = 8'($urandom);
            tick();
            if (c4 < 0 && !busy4) c4 = i;
            if (c2 < 0 && !busy2) c2 = i;
            if (c4 >= 0 && c2 >= 0) break;
        end
        we4 = 0; we2 = 0;
        chk("pulse_len4", c4, 32);
        chk("pulse_len2", c2, 32);
        sweep_zero("reclr");

        // Latch is back to 0 after reset
        wr4(3, 8'h02);
        probe4("latch_rst", 2, 1, 1'b0, 0, 0, 0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
